fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the SIMD AES core; sits directly upstream of the opcode decoder.
- Holds the PC and issues one-outstanding-request reads to instruction memory.
- Registers each returned instruction into an IF/ID pipeline slot, and exposes the opcode and operand-type fields the decoder consumes.
- Supports decode stall, branch redirect with in-flight discard, and a one-entry skid buffer.

Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 16, program counter / instruction address width.
- PC_INC, 1, PC increment per instruction (word-addressed memory).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  registered one-cycle read request pulse.
- imem_addr  out  PC_W  read address; valid while imem_req=1.
- imem_rvalid  in  1  read data valid; earliest one cycle after imem_req.
- imem_rdata  in  INSTR_W  instruction word.
- id_stall  in  1  decode cannot accept; hold the IF/ID slot.
- br_taken  in  1  redirect request (single-cycle pulse).
- br_target  in  PC_W  redirect address.
- id_valid  out  1  IF/ID slot holds a valid instruction.
- id_instr  out  INSTR_W  registered instruction.
- id_pc  out  PC_W  address of id_instr.
- id_opcode  out  5 ([0:4])  id_instr[INSTR_W-1:INSTR_W-5]; id_opcode[0] is the instruction MSB.
- id_rd_type, id_rs1_type, id_rs2_type  out  1 each  id_instr bits INSTR_W-6, INSTR_W-7, INSTR_W-8 (1 = vector register).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - pc=RESET_PC, state=ISSUE.
  - imem_req=0, imem_addr=RESET_PC.
  - id_valid=0, id_instr=0, id_pc=0, skid empty.
  - id_opcode and the type bits derive from id_instr, so they reset to 0.
- States:
  - ISSUE: imem_req=1 for one cycle with imem_addr=pc, then go to WAIT. ISSUE is not entered while the skid buffer is full.
  - WAIT: request outstanding; wait for imem_rvalid.
  - DROP: request outstanding but stale; on imem_rvalid, discard the data and go to ISSUE.
  - FULL: skid buffer occupied; no request is issued; leave when the skid drains.
- Accept in WAIT (imem_rvalid=1), where "slot free" means !id_valid || !id_stall:
  - Slot free: next cycle id_instr=rdata, id_pc=pc, id_valid=1. pc += PC_INC (mod 2^PC_W). Go to ISSUE.
  - Slot busy (id_valid && id_stall): capture {rdata, pc} in the skid buffer. pc += PC_INC. Go to FULL.
- FULL: the first cycle id_stall=0 moves the skid into IF/ID (id_valid stays 1) and clears the skid; go to ISSUE.
- Slot drain: if id_stall=0 and nothing new loads, id_valid goes to 0 next cycle.
- Stall: while id_stall=1, id_valid, id_instr and id_pc are held unchanged.
- Timing with 1-cycle memory:
  - imem_req at T, rvalid at T+1, id_valid at T+2, next imem_req at T+2.
  - Throughput is one instruction per 2 cycles.
- Redirect (br_taken=1) has priority over all other events in the same cycle:
  - Next cycle: pc=br_target, id_valid=0, skid cleared.
  - If a request is outstanding (WAIT, or imem_rvalid not yet seen), go to DROP.
  - Otherwise go to ISSUE.
  - An imem_rvalid in the redirect cycle is discarded, and the state goes to ISSUE.
  - br_taken while in DROP: update pc and stay in DROP.
  - The redirect flushes even when id_stall=1.
- PC wraps from 2^PC_W-PC_INC to 0 without error.
- imem_rvalid in ISSUE or FULL is ignored (protocol violation; an assertion fires in simulation).
- rst_n assertion mid-request forces all reset values immediately. A response arriving after reset release with no outstanding request is ignored.

Test Plan:
- Reset release, memory with 1-cycle latency returning 0xC0000000 at addr 0 and 0xB8000000 at addr 1 -> imem_req at cycles 0 and 2; id_valid at cycle 2 with id_pc=0, id_opcode=5'b11000; then id_pc=1, id_opcode=5'b10111.
- id_stall=1 held for 4 cycles while a response arrives -> IF/ID unchanged; skid captures the next word; no imem_req while FULL. On release, the skid word appears the next cycle and imem_req follows.
- br_taken with br_target=0x0040 while in WAIT -> id_valid=0 next cycle; the stale rvalid data is discarded; next imem_addr=0x0040; first delivered id_pc=0x0040.
- br_taken in the same cycle as imem_rvalid and id_stall=1 -> response discarded, id_valid=0, skid empty, imem_req with imem_addr=br_target within 1 cycle.
- RESET_PC=0xFFFF, PC_INC=1 -> second fetch address is 0x0000.
- rst_n pulsed low while in WAIT -> outputs reset asynchronously; after release the first imem_addr=RESET_PC and a late rvalid is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - Instruction fetch: PC, single-outstanding imem reads, IF/ID slot with one-entry skid.
module fetch_stage #(
    parameter int INSTR_W  = 32,
    parameter int PC_W     = 16,
    parameter int PC_INC   = 1,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               id_stall,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [0:4]         id_opcode,
    output logic               id_rd_type,
    output logic               id_rs1_type,
    output logic               id_rs2_type
);

    typedef enum logic [1:0] {ISSUE, WAIT, DROP, FULL} state_t;

    state_t             state, state_next;
    logic [PC_W-1:0]    pc, pc_next, pc_inc;
    logic               slot_free;
    logic               load_rdata, load_skid, capture_skid;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    assign slot_free = !id_valid || !id_stall;
    assign pc_inc    = pc + PC_W'(PC_INC);

    assign id_opcode   = id_instr[INSTR_W-1 -: 5];
    assign id_rd_type  = id_instr[INSTR_W-6];
    assign id_rs1_type = id_instr[INSTR_W-7];
    assign id_rs2_type = id_instr[INSTR_W-8];

    // ISSUE is the cycle imem_req is visible; only the first cycle after reset sits in ISSUE with imem_req low.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        load_rdata   = 1'b0;
        load_skid    = 1'b0;
        capture_skid = 1'b0;
        if (br_taken) begin
            pc_next = br_target;
            case (state)
                WAIT:    state_next = imem_rvalid ? ISSUE : DROP;
                DROP:    state_next = imem_rvalid ? ISSUE : DROP;
                ISSUE:   state_next = imem_req ? DROP : ISSUE;
                default: state_next = ISSUE;
            endcase
        end else begin
            case (state)
                ISSUE: begin
                    if (imem_req) state_next = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        pc_next = pc_inc;
                        if (slot_free) begin
                            load_rdata = 1'b1;
                            state_next = ISSUE;
                        end else begin
                            capture_skid = 1'b1;
                            state_next   = FULL;
                        end
                    end
                end
                DROP: begin
                    if (imem_rvalid) state_next = ISSUE;
                end
                FULL: begin
                    if (!id_stall) begin
                        load_skid  = 1'b1;
                        state_next = ISSUE;
                    end
                end
                default: state_next = ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ISSUE;
            pc         <= PC_W'(RESET_PC);
            imem_req   <= 1'b0;
            imem_addr  <= PC_W'(RESET_PC);
            id_valid   <= 1'b0;
            id_instr   <= '0;
            id_pc      <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            imem_req  <= (state_next == ISSUE);
            imem_addr <= pc_next;
            if (br_taken) begin
                id_valid <= 1'b0;
            end else if (load_rdata) begin
                id_valid <= 1'b1;
                id_instr <= imem_rdata;
                id_pc    <= pc;
            end else if (load_skid) begin
                id_valid <= 1'b1;
                id_instr <= skid_instr;
                id_pc    <= skid_pc;
            end else if (!id_stall) begin
                id_valid <= 1'b0;
            end
            if (capture_skid) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end
        end
    end

    // A response while issuing or while the skid is full has no matching request.
    rvalid_protocol: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && (state == FULL || (state == ISSUE && imem_req))));

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_rvalid;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_stall, br_taken;
    logic [15:0] br_target;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [15:0] id_pc;
    logic [0:4]  id_opcode;
    logic        id_rd_type, id_rs1_type, id_rs2_type;

    logic        w_req, w_rvalid, w_valid;
    logic [15:0] w_addr, w_pc;
    logic [31:0] w_rdata, w_instr;
    logic [0:4]  w_opcode;
    logic        w_rd_type, w_rs1_type, w_rs2_type;

    logic        mem_auto;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_stall(id_stall), .br_taken(br_taken), .br_target(br_target),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_rd_type(id_rd_type),
        .id_rs1_type(id_rs1_type), .id_rs2_type(id_rs2_type)
    );

    fetch_stage #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .id_stall(1'b0), .br_taken(1'b0), .br_target(16'h0000),
        .id_valid(w_valid), .id_instr(w_instr), .id_pc(w_pc),
        .id_opcode(w_opcode), .id_rd_type(w_rd_type),
        .id_rs1_type(w_rs1_type), .id_rs2_type(w_rs2_type)
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 32'hC000_0000;
        if (a == 16'h0001) return 32'hB800_0000;
        return 32'h5E00_0000 | 32'(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: both memories answer one cycle after a visible request.
    task automatic tick();
        logic        p_req, pw_req;
        logic [15:0] p_addr, pw_addr;
        p_req   = imem_req;
        p_addr  = imem_addr;
        pw_req  = w_req;
        pw_addr = w_addr;
        @(posedge clk);
        #1;
        imem_rvalid = mem_auto && p_req;
        imem_rdata  = mem_word(p_addr);
        w_rvalid    = pw_req;
        w_rdata     = mem_word(pw_addr);
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        w_rvalid    = 1'b0;
        w_rdata     = '0;
        id_stall    = 1'b0;
        br_taken    = 1'b0;
        br_target   = '0;
        mem_auto    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",    32'(imem_req),  32'd0);
        check("rst_addr",   32'(imem_addr), 32'd0);
        check("rst_valid",  32'(id_valid),  32'd0);
        check("rst_instr",  id_instr,       32'd0);
        check("rst_pc",     32'(id_pc),     32'd0);
        check("rst_opcode", 32'(id_opcode), 32'd0);
        check("rst_w_addr", 32'(w_addr),    32'h0000_FFFF);
        rst_n = 1'b1;

        tick();
        check("c0_req",    32'(imem_req), 32'd1);
        check("c0_addr",   32'(imem_addr), 32'd0);
        check("wrap_addr0", 32'(w_addr),  32'h0000_FFFF);
        tick();
        check("c1_req",   32'(imem_req), 32'd0);
        check("c1_valid", 32'(id_valid), 32'd0);
        tick();
        check("c2_valid",  32'(id_valid),  32'd1);
        check("c2_pc",     32'(id_pc),     32'd0);
        check("c2_opcode", 32'(id_opcode), 32'h18);
        check("c2_req",    32'(imem_req),  32'd1);
        check("c2_addr",   32'(imem_addr), 32'd1);
        check("wrap_addr1", 32'(w_addr),   32'd0);
        check("wrap_pc0",   32'(w_pc),     32'h0000_FFFF);
        tick();
        tick();
        check("c4_valid",  32'(id_valid),  32'd1);
        check("c4_pc",     32'(id_pc),     32'd1);
        check("c4_opcode", 32'(id_opcode), 32'h17);
        check("c4_instr",  id_instr,       32'hB800_0000);

        id_stall = 1'b1;
        tick();
        check("stall_pc0",  32'(id_pc),    32'd1);
        check("stall_req0", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_req",   32'(imem_req), 32'd0);
            check("full_pc",    32'(id_pc),    32'd1);
            check("full_valid", 32'(id_valid), 32'd1);
        end
        id_stall = 1'b0;
        tick();
        check("skid_pc",    32'(id_pc),     32'd2);
        check("skid_instr", id_instr,       32'h5E00_0002);
        check("skid_req",   32'(imem_req),  32'd1);
        check("skid_addr",  32'(imem_addr), 32'd3);

        mem_auto = 1'b0;
        tick();
        check("drain_valid", 32'(id_valid), 32'd0);
        br_taken  = 1'b1;
        br_target = 16'h0040;
        tick();
        br_taken = 1'b0;
        check("br_valid", 32'(id_valid), 32'd0);
        check("br_req",   32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        check("drop_req",   32'(imem_req),  32'd1);
        check("drop_addr",  32'(imem_addr), 32'h40);
        check("drop_valid", 32'(id_valid),  32'd0);
        mem_auto = 1'b1;
        tick();
        tick();
        check("br_first_valid", 32'(id_valid), 32'd1);
        check("br_first_pc",    32'(id_pc),    32'h40);
        check("br_first_instr", id_instr,      32'h5E00_0040);

        id_stall = 1'b1;
        tick();
        br_taken  = 1'b1;
        br_target = 16'h0100;
        tick();
        br_taken = 1'b0;
        id_stall = 1'b0;
        check("brs_valid", 32'(id_valid),  32'd0);
        check("brs_req",   32'(imem_req),  32'd1);
        check("brs_addr",  32'(imem_addr), 32'h100);
        tick();
        check("brs_empty", 32'(id_valid), 32'd0);
        tick();
        check("brs_pc",     32'(id_pc),       32'h100);
        check("brs_instr",  id_instr,         32'h5E00_0100);
        check("brs_opcode", 32'(id_opcode),   32'h0B);
        check("brs_rd",     32'(id_rd_type),  32'd1);
        check("brs_rs1",    32'(id_rs1_type), 32'd1);
        check("brs_rs2",    32'(id_rs2_type), 32'd0);

        mem_auto = 1'b0;
        tick();
        check("wait_pc",   32'(id_pc),     32'h100);
        check("wait_addr", 32'(imem_addr), 32'h101);
        #1 rst_n = 1'b0;
        #1;
        check("arst_req",   32'(imem_req),  32'd0);
        check("arst_addr",  32'(imem_addr), 32'd0);
        check("arst_valid", 32'(id_valid),  32'd0);
        check("arst_pc",    32'(id_pc),     32'd0);
        check("arst_instr", id_instr,       32'd0);
        #1 rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        check("late_req",   32'(imem_req),  32'd1);
        check("late_addr",  32'(imem_addr), 32'd0);
        check("late_valid", 32'(id_valid),  32'd0);
        mem_auto = 1'b1;
        tick();
        tick();
        check("post_valid", 32'(id_valid), 32'd1);
        check("post_pc",    32'(id_pc),    32'd0);
        check("post_instr", id_instr,      32'hC000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
